// File: rtl/saat_uart_verici.sv
// saat_uart_verici: UART 8N1 transmitter that sends a snapshot of the time of day as "HH:MM:SS\r\n".
// Ports:
//   CLK    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   gonder - send request, honoured only while idle
//   saat, dakika, saniye - binary hours/minutes/seconds, latched on an accepted gonder
//   tx     - serial output, idle high, registered
//   mesgul - high while a line is in flight
//   bitti  - one-cycle pulse after the last stop bit
// Optional: define TARIH_GONDER_EN to add gun/ay/yil inputs and send "DD.MM.YY HH:MM:SS\r\n".
module saat_uart_verici #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       gonder,
  input  logic [4:0] saat,
  input  logic [5:0] dakika,
  input  logic [5:0] saniye,
`ifdef TARIH_GONDER_EN
  input  logic [4:0] gun,
  input  logic [3:0] ay,
  input  logic [6:0] yil,
`endif
  output logic       tx,
  output logic       mesgul,
  output logic       bitti
);
  typedef enum logic [2:0] {BOSTA, BASLA, VERI, DUR, BITIS} state_t;
  localparam logic [15:0] CMAX = 16'(CLKS_PER_BIT - 1);
`ifdef TARIH_GONDER_EN
  localparam int N = 19;
`else
  localparam int N = 10;
`endif
  localparam logic [4:0] LAST = 5'(N - 1);
  // Two ASCII decimal digits, tens first; values above 99 are not clamped.
  function automatic logic [15:0] dec2(input logic [6:0] v);
    dec2 = {8'h30 + {1'b0, v / 7'd10}, 8'h30 + {1'b0, v % 7'd10}};
  endfunction
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] chr_q, chr_d;
  logic [4:0] saat_q;
  logic [5:0] dak_q, san_q;
  logic tx_q, tx_d, mesgul_q, bitti_q;
  logic [8*N-1:0] line;
  logic [7:0] ch;
  logic snap;
  assign snap = (state_q == BOSTA) && gonder;
`ifdef TARIH_GONDER_EN
  logic [4:0] gun_q;
  logic [3:0] ay_q;
  logic [6:0] yil_q;
  assign line = {dec2({2'b0, gun_q}), 8'h2E, dec2({3'b0, ay_q}), 8'h2E, dec2(yil_q), 8'h20,
                 dec2({2'b0, saat_q}), 8'h3A, dec2({1'b0, dak_q}), 8'h3A, dec2({1'b0, san_q}),
                 8'h0D, 8'h0A};
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      gun_q <= '0;
      ay_q  <= '0;
      yil_q <= '0;
    end else if (snap) begin
      gun_q <= gun;
      ay_q  <= ay;
      yil_q <= yil;
    end
`else
  assign line = {dec2({2'b0, saat_q}), 8'h3A, dec2({1'b0, dak_q}), 8'h3A, dec2({1'b0, san_q}),
                 8'h0D, 8'h0A};
`endif
  // Character 0 sits in the most significant byte of the line.
  assign ch = line[8*(N-1-int'(chr_q)) +: 8];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    case (state_q)
      BOSTA: if (gonder) begin
        state_d = BASLA;
        cnt_d   = CMAX;
        chr_d   = '0;
      end
      BASLA: if (cnt_q == 0) begin
        state_d = VERI;
        cnt_d   = CMAX;
        bit_d   = '0;
      end else cnt_d = cnt_q - 16'd1;
      VERI: if (cnt_q == 0) begin
        cnt_d = CMAX;
        if (bit_q == 3'd7) state_d = DUR;
        else bit_d = bit_q + 3'd1;
      end else cnt_d = cnt_q - 16'd1;
      DUR: if (cnt_q == 0) begin
        cnt_d = CMAX;
        if (chr_q == LAST) state_d = BITIS;
        else begin
          state_d = BASLA;
          chr_d   = chr_q + 5'd1;
        end
      end else cnt_d = cnt_q - 16'd1;
      BITIS: begin
        state_d = BOSTA;
        chr_d   = '0;
      end
      default: state_d = BOSTA;
    endcase
    // tx is computed from the next state so the pin changes on the same edge as the FSM.
    tx_d = state_d == BASLA ? 1'b0 : state_d == VERI ? ch[bit_d] : 1'b1;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state_q  <= BOSTA;
      cnt_q    <= '0;
      bit_q    <= '0;
      chr_q    <= '0;
      saat_q   <= '0;
      dak_q    <= '0;
      san_q    <= '0;
      tx_q     <= 1'b1;
      mesgul_q <= 1'b0;
      bitti_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      chr_q    <= chr_d;
      tx_q     <= tx_d;
      mesgul_q <= (state_d == BASLA) || (state_d == VERI) || (state_d == DUR);
      bitti_q  <= state_d == BITIS;
      if (snap) begin
        saat_q <= saat;
        dak_q  <= dakika;
        san_q  <= saniye;
      end
    end
  assign tx     = tx_q;
  assign mesgul = mesgul_q;
  assign bitti  = bitti_q;
endmodule

// File: doc/saat_uart_verici.md
Name: saat_uart_verici

Overview:
- UART transmitter that reports the current time of day as an ASCII line on `tx`, e.g. "HH:MM:SS\r\n".
- It is the transmit end of the serial link whose receive end sets the clock from the host.
- It sits between the time-keeping counters and the board `tx` pin, inside the clock-update block.
- A one-cycle `gonder` pulse snapshots the time and sends one 8N1 line.

Parameters:
- CLKS_PER_BIT, 10416, CLK cycles per UART bit (100 MHz / 9600 baud); legal range 2 to 65535.

Ports:
- CLK  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- gonder  input  1  send request, sampled on CLK; honoured only while idle.
- saat  input  5  hours, binary 0-23.
- dakika  input  6  minutes, binary 0-59.
- saniye  input  6  seconds, binary 0-59.
- tx  output  1  UART serial output, idle high.
- mesgul  output  1  high while a line is being sent.
- bitti  output  1  one-cycle pulse when the line has completed.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, mesgul=0, bitti=0.
  - State=BOSTA; all counters and the snapshot cleared.
  - Reset asserted mid-line aborts the line immediately: tx returns high with no stop bit, and no `bitti` is issued.
- Snapshot:
  - On the edge where gonder=1 and state=BOSTA, latch saat, dakika and saniye.
  - The transmitted line uses only the latched values; later input changes do not affect it.
- Formatting:
  - Each field becomes two ASCII decimal digits: tens = value/10, ones = value%10, each digit = 0x30 + d.
  - Fields are not range-checked: 63 transmits "63", and saat 31 transmits "31".
  - Line = tens/ones of saat, 0x3A ':', dakika, 0x3A, saniye, 0x0D, 0x0A. 10 characters, index 0-9.
- Framing (per character, 8N1):
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Every bit holds for exactly CLKS_PER_BIT cycles.
  - No idle gap between characters: the next start bit follows the previous stop bit directly.
- State machine:
  - BOSTA -> BASLA when gonder=1.
  - BASLA (tx=0) -> VERI.
  - VERI (8 bits) -> DUR.
  - DUR (tx=1) -> BASLA if character index < last, otherwise -> BITIS.
  - BITIS lasts 1 cycle, then -> BOSTA.
- Latency and timing:
  - With gonder sampled at edge k: mesgul=1 and tx=0 from edge k (registered outputs visible after edge k).
  - Line duration is 100*CLKS_PER_BIT cycles.
  - bitti=1 for exactly one cycle (BITIS) after the last stop bit ends; mesgul falls on the same edge bitti rises.
- Boundary conditions:
  - gonder while mesgul=1: ignored, not queued.
  - gonder held high: starts one line; a new line starts on the first cycle after BITIS in which gonder=1 is sampled in BOSTA.
  - gonder in the BITIS cycle: ignored.
  - Bit counter counts down from CLKS_PER_BIT-1 to 0.
  - Character index wraps to 0 only via BOSTA.
- tx is driven from a flip-flop; it is glitch-free.

Optional Feature:
- Macro: TARIH_GONDER_EN.
- Defined:
  - Adds inputs gun[4:0] (1-31), ay[3:0] (1-12), yil[6:0] (0-99, year 2000+yil), all latched in the same snapshot as the time.
  - Line becomes "DD.MM.YY HH:MM:SS\r\n" (19 characters, 0x2E '.', 0x20 space).
  - Line duration is 190*CLKS_PER_BIT cycles.
- Undefined: these ports do not exist and the behaviour is exactly as above.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset low, then released → tx=1, mesgul=0, bitti=0; no activity for 100 cycles with gonder=0.
- saat=13, dakika=5, saniye=59, one gonder pulse → bench UART decoder receives 0x31 0x33 0x3A 0x30 0x35 0x3A 0x35 0x39 0x0D 0x0A; each bit is 4 cycles; bitti pulses once, 400 cycles after the gonder edge.
- Change saniye from 59 to 0 right after gonder → the transmitted line still reads "59".
- Pulse gonder again at cycle 150 of a line → ignored; exactly 10 characters are received and a single bitti.
- Assert reset during character 4 → tx=1 within the same cycle, mesgul=0, no bitti; a subsequent gonder sends a complete fresh line.
- TARIH_GONDER_EN defined, gun=7, ay=3, yil=25, time 00:00:00 → "07.03.25 00:00:00\r\n", 19 characters, 760 cycles.
